// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: queues set/clear strobes and plays them out as gapped S/R pulses
// to an SRFF, checking its Q against the expected state after each pulse.
module sr_drive_ctrl #(
   parameter int DEPTH        = 4,
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic set_req,
   input  logic clr_req,
   input  logic q_fb,
   output logic req_ready,
   output logic S,
   output logic R,
   output logic busy,
   output logic q_expect,
   output logic overflow,
   output logic conflict,
   output logic mismatch
);
   localparam int AW = $clog2(DEPTH);
   localparam int MX = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW = $clog2(MX) + 1;
   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
   state_t state;
   logic [DEPTH-1:0] mem;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic [CW-1:0] cnt;
   logic cmd, push, pop;
   assign req_ready = count != (AW+1)'(DEPTH);
   assign push = (set_req ^ clr_req) & req_ready;
   assign pop = state == IDLE && count != '0;
   assign busy = state != IDLE || count != '0;
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         cnt <= '0;
         cmd <= 1'b0;
         S <= 1'b0;
         R <= 1'b0;
         q_expect <= 1'b0;
         overflow <= 1'b0;
         conflict <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= set_req;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (set_req & clr_req) conflict <= 1'b1;
         if ((set_req | clr_req) & ~req_ready) overflow <= 1'b1;
         case (state)
            IDLE: if (pop) begin
               cmd <= mem[rd_ptr];
               S <= mem[rd_ptr];
               R <= ~mem[rd_ptr];
               cnt <= CW'(PULSE_CYCLES - 1);
               state <= PULSE;
            end
            PULSE: if (cnt == '0) begin
               S <= 1'b0;
               R <= 1'b0;
               q_expect <= cmd;
               cnt <= CW'(GAP_CYCLES - 1);
               state <= GAP;
            end else cnt <= cnt - 1'b1;
            GAP: if (cnt == '0) begin
               if (q_fb != q_expect) mismatch <= 1'b1;
               state <= IDLE;
            end else cnt <= cnt - 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
